// File: rtl/crc8_packet_feeder_pkg.sv
// crc8_feeder_pkg: shared types and constants for the CRC8816 packet feeder
package crc8_feeder_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, REPORT} state_t;
  localparam int CRC_BYTE_W = 8;
  localparam int TIMEOUT_CYCLES_DEFAULT = 64;
  // Payload leaves MSB byte first, the expected CRC byte goes out last
  localparam bit BYTE_ORDER_MSB_FIRST = 1'b1;
endpackage

// File: rtl/crc8_byte_serializer.sv
// crc8_byte_serializer: loads payload plus CRC byte and emits it MSB byte first with valid/last
module crc8_byte_serializer import crc8_feeder_pkg::*; #(
  parameter int DATA_LENGTH = 32,
  parameter int DATA_LENGTH_BYTES = DATA_LENGTH / 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [DATA_LENGTH-1:0] payload,
  input  logic [CRC_BYTE_W-1:0]  crc,
  output logic                   valid,
  output logic                   last,
  output logic [CRC_BYTE_W-1:0]  data
);
  localparam int CW = $clog2(DATA_LENGTH_BYTES + 1);
  localparam int SW = DATA_LENGTH + CRC_BYTE_W;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_LENGTH_BYTES);
  logic [SW-1:0] sr;
  logic [CW-1:0] cnt;
  // Shift one byte out per cycle from load until the CRC byte has been shown
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
      cnt <= '0;
      valid <= 1'b0;
    end else if (load) begin
      sr <= {payload, crc};
      cnt <= '0;
      valid <= 1'b1;
    end else if (valid) begin
      sr <= sr << CRC_BYTE_W;
      cnt <= cnt + CW'(1);
      valid <= !last;
    end
  end
  assign last = valid && (cnt == LAST_IDX);
  assign data = valid ? sr[SW-1 -: CRC_BYTE_W] : '0;
endmodule

// File: rtl/crc8_packet_feeder.sv
// crc8_packet_feeder: streams one packet into CRC8816 and reports its result; CRC8_FEEDER_TIMEOUT_EN adds a WAIT_DONE watchdog
module crc8_packet_feeder import crc8_feeder_pkg::*; #(
  parameter int DATA_LENGTH = 32,
  parameter int DATA_LENGTH_BYTES = DATA_LENGTH / 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [DATA_LENGTH-1:0] i_payload,
  input  logic [CRC_BYTE_W-1:0]  i_crc_expected,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic                   o_last,
  output logic [CRC_BYTE_W-1:0]  o_data,
  input  logic                   i_done,
  input  logic                   i_match,
  input  logic [CRC_BYTE_W-1:0]  i_crc8,
  output logic                   o_result_valid,
  output logic                   o_result_match,
  output logic [CRC_BYTE_W-1:0]  o_result_crc8,
  output logic                   o_err_proto,
  output logic                   o_err_timeout
);
  if (DATA_LENGTH % 8 != 0 || DATA_LENGTH < 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("crc8_packet_feeder: DATA_LENGTH must be a multiple of 8 (>=8) and TIMEOUT_CYCLES >= 1");
  end
  state_t state;
  logic load;
  assign load = (state == IDLE) && i_start;
  crc8_byte_serializer #(.DATA_LENGTH(DATA_LENGTH), .DATA_LENGTH_BYTES(DATA_LENGTH_BYTES)) u_ser (
    .clk(clk), .reset(reset), .load(load), .payload(i_payload), .crc(i_crc_expected),
    .valid(o_valid), .last(o_last), .data(o_data)
  );
`ifdef CRC8_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`else
  assign o_err_timeout = 1'b0;
`endif
  // Packet FSM with registered handshake, result capture and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      o_ready <= 1'b1;
      o_result_valid <= 1'b0;
      o_result_match <= 1'b0;
      o_result_crc8 <= '0;
      o_err_proto <= 1'b0;
`ifdef CRC8_FEEDER_TIMEOUT_EN
      o_err_timeout <= 1'b0;
      tcnt <= '0;
`endif
    end else begin
      o_result_valid <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          state <= SEND;
          o_ready <= 1'b0;
          o_result_match <= 1'b0;
          o_result_crc8 <= '0;
          o_err_proto <= 1'b0;
`ifdef CRC8_FEEDER_TIMEOUT_EN
          o_err_timeout <= 1'b0;
`endif
        end
        SEND: begin
          if (o_last) state <= WAIT_DONE;
`ifdef CRC8_FEEDER_TIMEOUT_EN
          tcnt <= '0;
`endif
        end
        WAIT_DONE: if (i_done) begin
          state <= REPORT;
          o_result_valid <= 1'b1;
          o_result_match <= i_match;
          o_result_crc8 <= i_crc8;
        end
`ifdef CRC8_FEEDER_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state <= REPORT;
          o_result_valid <= 1'b1;
          o_result_match <= 1'b0;
          o_result_crc8 <= '0;
          o_err_timeout <= 1'b1;
        end else tcnt <= tcnt + TW'(1);
`endif
        REPORT: begin
          state <= IDLE;
          o_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (i_done && state != WAIT_DONE) o_err_proto <= 1'b1;
    end
  end
endmodule

// File: tb/tb_crc8_packet_feeder.sv
// tb_crc8_packet_feeder: directed vectors for the CRC8816 packet feeder
module tb_crc8_packet_feeder;
  logic clk = 1'b0, reset = 1'b1, i_start = 1'b0, i_done = 1'b0, i_match = 1'b0;
  logic [31:0] i_payload = '0;
  logic [7:0] i_crc_expected = '0, i_crc8 = '0;
  logic o_ready, o_valid, o_last, o_result_valid, o_result_match, o_err_proto, o_err_timeout;
  logic [7:0] o_data, o_result_crc8;
  int vectors = 0, miscompares = 0;

  crc8_packet_feeder #(.DATA_LENGTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_payload(i_payload),
    .i_crc_expected(i_crc_expected), .o_ready(o_ready), .o_valid(o_valid),
    .o_last(o_last), .o_data(o_data), .i_done(i_done), .i_match(i_match),
    .i_crc8(i_crc8), .o_result_valid(o_result_valid), .o_result_match(o_result_match),
    .o_result_crc8(o_result_crc8), .o_err_proto(o_err_proto), .o_err_timeout(o_err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_data", o_data, 0);
    chk("rst_rvalid", o_result_valid, 0);
    chk("rst_match", o_result_match, 0);
    chk("rst_crc8", o_result_crc8, 0);
    chk("rst_proto", o_err_proto, 0);
    chk("rst_timeout", o_err_timeout, 0);
  endtask

  // start a packet and check its byte stream; optionally pulse start or reset at a byte index
  task automatic stream(input logic [31:0] p, input logic [7:0] c, input int start_at, input int reset_at);
    logic [39:0] e;
    e = {p, c};
    i_payload = p;
    i_crc_expected = c;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_payload = '0;
    i_crc_expected = '0;
    chk("clr_match", o_result_match, 0);
    chk("clr_crc8", o_result_crc8, 0);
    chk("clr_proto", o_err_proto, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("data%0d", i), o_data, e[39-8*i -: 8]);
      chk($sformatf("valid%0d", i), o_valid, 1);
      chk($sformatf("last%0d", i), o_last, (i == 4) ? 1 : 0);
      chk($sformatf("ready%0d", i), o_ready, 0);
      if (i == reset_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        return;
      end
      i_start = (i == start_at);
      tick();
      i_start = 1'b0;
    end
    chk("post_valid", o_valid, 0);
    chk("post_data", o_data, 0);
    chk("post_last", o_last, 0);
  endtask

  initial begin
    int pulses;
    tick();
    tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();
    chk_reset_vals();

    stream(32'hDEADBEEF, 8'h5A, -1, -1);
    tick();
    i_done = 1'b1; i_match = 1'b1; i_crc8 = 8'h5A;
    tick();
    i_done = 1'b0; i_match = 1'b0; i_crc8 = 8'h00;
    chk("p1_rvalid", o_result_valid, 1);
    chk("p1_match", o_result_match, 1);
    chk("p1_crc8", o_result_crc8, 8'h5A);
    chk("p1_ready_rep", o_ready, 0);
    tick();
    chk("p1_rvalid_off", o_result_valid, 0);
    chk("p1_ready_back", o_ready, 1);
    tick();
    tick();
    chk("p1_hold_match", o_result_match, 1);
    chk("p1_hold_crc8", o_result_crc8, 8'h5A);
    chk("p1_proto", o_err_proto, 0);

    stream(32'h01234567, 8'hC3, 1, -1);
    i_done = 1'b1; i_match = 1'b0; i_crc8 = 8'h77;
    tick();
    i_done = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (o_result_valid) pulses++;
      tick();
    end
    chk("p2_pulses", pulses, 1);
    chk("p2_match", o_result_match, 0);
    chk("p2_crc8", o_result_crc8, 8'h77);
    chk("p2_valid_idle", o_valid, 0);
    chk("p2_proto", o_err_proto, 0);

    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    chk("idle_proto", o_err_proto, 1);
    chk("idle_ready", o_ready, 1);
    tick();
    chk("idle_proto_sticky", o_err_proto, 1);
    chk("idle_still_ready", o_ready, 1);
    chk("idle_no_valid", o_valid, 0);

    stream(32'hA1B2C3D4, 8'h99, -1, 2);
    chk_reset_vals();
    tick();
    tick();
    chk("no_stale_valid", o_valid, 0);
    chk("no_stale_ready", o_ready, 1);

    stream(32'h0F1E2D3C, 8'h4B, -1, -1);
    i_done = 1'b1; i_match = 1'b1; i_crc8 = 8'h4B;
    tick();
    i_done = 1'b0;
    chk("p4_rvalid", o_result_valid, 1);
    chk("p4_match", o_result_match, 1);
    chk("p4_crc8", o_result_crc8, 8'h4B);
    tick();

`ifdef CRC8_FEEDER_TIMEOUT_EN
    stream(32'h11223344, 8'h55, -1, -1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("to_early_rvalid", o_result_valid, 0);
    end
    tick();
    chk("to_rvalid", o_result_valid, 1);
    chk("to_flag", o_err_timeout, 1);
    chk("to_match", o_result_match, 0);
    chk("to_crc8", o_result_crc8, 0);
    tick();
    chk("to_ready", o_ready, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/crc8_packet_feeder.md
Name: crc8_packet_feeder

Overview:
Upstream stage of the CRC8816 checker. Accepts one packet (DATA_LENGTH-bit payload plus expected CRC byte) on a start strobe. Streams the packet into CRC8816 as bytes on a valid/last interface, waits for the checker's done, then captures and reports match and CRC results to the controlling logic.

Parameters:
DATA_LENGTH, 32, payload width in bits; multiple of 8, minimum 8.
DATA_LENGTH_BYTES, DATA_LENGTH/8, number of payload bytes streamed.
TIMEOUT_CYCLES, 64, WAIT_DONE watchdog limit; used only with the optional feature; minimum 1.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
i_start  in  1  packet start strobe; accepted only when o_ready=1.
i_payload  in  DATA_LENGTH  payload; sampled on accepted start.
i_crc_expected  in  8  expected CRC byte; sampled on accepted start.
o_ready  out  1  high in IDLE only.
o_valid  out  1  byte valid toward CRC8816 (drives its i_valid).
o_last  out  1  final byte marker (drives i_last).
o_data  out  8  byte toward CRC8816 (drives i_data).
i_done  in  1  from CRC8816 o_done.
i_match  in  1  from CRC8816 o_match.
i_crc8  in  8  from CRC8816 o_crc8 (low 8 bits).
o_result_valid  out  1  one-cycle pulse when a result is available.
o_result_match  out  1  captured match; held until next accepted start.
o_result_crc8  out  8  captured computed CRC; held until next accepted start.
o_err_proto  out  1  sticky; i_done seen outside WAIT_DONE; cleared on accepted start.
o_err_timeout  out  1  sticky; watchdog expired; cleared on accepted start.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state IDLE, o_ready=1, o_valid=0, o_last=0, o_data=8'h00, o_result_valid=0, o_result_match=0, o_result_crc8=8'h00, both error flags 0.
- FSM states: IDLE, SEND, WAIT_DONE, REPORT.
- IDLE:
  - i_start=1 latches {i_payload, i_crc_expected} into a (DATA_LENGTH+8)-bit shift register.
  - Clears the held result and both error flags.
  - Moves to SEND.
- SEND:
  - Emits one byte per cycle with o_valid=1 and no gaps.
  - Order: payload MSB byte first (i_payload[DATA_LENGTH-1 -: 8]), then the remaining payload bytes, then the CRC byte.
  - o_last=1 only on the CRC byte, which is byte index DATA_LENGTH_BYTES, 0-based.
  - Start accepted at edge t gives the first byte valid in cycle t+1 and the last byte in cycle t+1+DATA_LENGTH_BYTES.
  - After the last byte, move to WAIT_DONE.
  - The byte counter is $clog2(DATA_LENGTH_BYTES+1) bits wide.
- Outside SEND: o_valid=0, o_last=0, o_data=8'h00.
- WAIT_DONE:
  - On i_done=1, capture i_match and i_crc8 and move to REPORT.
  - i_done is accepted in the same cycle the last byte is emitted only if the checker is combinational. Default: i_done is ignored until WAIT_DONE is entered.
- REPORT:
  - o_result_valid=1 for exactly one cycle, then IDLE.
  - o_ready returns to 1 the cycle after REPORT.
- Start handling: i_start while not IDLE is ignored and not queued. i_start in IDLE at the same edge as reset: reset wins.
- Protocol error: i_done=1 in IDLE, SEND or REPORT sets o_err_proto and does not change state.
- Reset mid-operation: any state returns to IDLE next cycle with reset values; a partially sent packet is abandoned. CRC8816 shares the reset, so no stale last byte is issued.
- DATA_LENGTH not a multiple of 8: elaboration-time $error.

Optional Feature:
Macro CRC8_FEEDER_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits runs in WAIT_DONE.
  - If TIMEOUT_CYCLES cycles elapse without i_done: set o_err_timeout, force o_result_match=0 and o_result_crc8=8'h00, then go to REPORT (o_result_valid still pulses).
  - i_done in the expiry cycle wins over the timeout.
- Undefined: no counter; WAIT_DONE waits indefinitely; o_err_timeout tied to 0.

Decomposition:
- Package crc8_feeder_pkg:
  - state enum typedef (IDLE/SEND/WAIT_DONE/REPORT);
  - CRC_BYTE_W=8;
  - default TIMEOUT_CYCLES constant;
  - byte-order localparam documentation constant.
- One sub-module, crc8_byte_serializer:
  - load/shift register plus byte counter;
  - generates o_data/o_valid/o_last;
  - FSM and result capture stay in the top.

Test Plan:
- Reset, then start with i_payload=32'hDEADBEEF, i_crc_expected=8'h5A -> bytes DE, AD, BE, EF, 5A on cycles t+1..t+5, o_last only on 5A, o_ready=0 throughout.
- Drive i_done=1, i_match=1, i_crc8=8'h5A two cycles after last -> o_result_valid pulses once; o_result_match=1 and o_result_crc8=8'h5A held until next start.
- i_start pulsed during SEND -> ignored; byte stream unchanged; exactly one result produced.
- i_done pulsed in IDLE -> o_err_proto=1, state stays IDLE; next accepted start clears it.
- Reset asserted on the third byte -> next cycle o_valid=0 and all outputs at reset values; a new packet streams correctly.
- With CRC8_FEEDER_TIMEOUT_EN and TIMEOUT_CYCLES=4, never assert i_done -> o_err_timeout=1 and o_result_valid pulses 4 cycles after WAIT_DONE entry with match=0.
